// File: rtl/mul_usg_seq.sv
// mul_usg_seq: sequential shift-and-add multiplier, retires K multiplier bits per cycle with
// valid/ready handshakes on both sides. Optional macro MUL_SIGNED_EN adds two's-complement mode.
module mul_usg_seq #(
  parameter int N = 11,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
`ifdef MUL_SIGNED_EN
  input  logic           sign_mode,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Z,
  output logic           busy
);

  localparam int L  = (N + K - 1) / K;
  localparam int BW = L * K;
  localparam int AW = 2 * N + K;
  localparam int IW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic           accept_s;
  logic           step_s;
  logic           last_s;
  logic [AW-1:0]  mcand_r;
  logic [AW-1:0]  acc_r;
  logic [AW-1:0]  prod_s;
  logic [AW-1:0]  acc_nx_s;
  logic [BW-1:0]  mplier_r;
  logic [IW-1:0]  iter_r;
  logic [2*N-1:0] z_r;
  logic [2*N-1:0] z_nx_s;
  logic [N-1:0]   a_lat_s;
  logic [N-1:0]   b_lat_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;

`ifdef MUL_SIGNED_EN
  logic neg_r;
  logic neg_in_s;

  // The most negative operand maps to 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sm);
    logic [N-1:0] m;
    if (sm && v[N-1]) begin
      m = ~v + N'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  function automatic logic [2*N-1:0] negate(input logic [2*N-1:0] v);
    return ~v + (2*N)'(1);
  endfunction

  assign a_lat_s  = magnitude(A, sign_mode);
  assign b_lat_s  = magnitude(B, sign_mode);
  assign neg_in_s = sign_mode & (A[N-1] ^ B[N-1]);
  assign z_nx_s   = neg_r ? negate(acc_nx_s[2*N-1:0]) : acc_nx_s[2*N-1:0];
`else
  assign a_lat_s  = A;
  assign b_lat_s  = B;
  assign z_nx_s   = acc_nx_s[2*N-1:0];
`endif

  // Multiplicand is pre-shifted each step, so the low K multiplier bits always weight it correctly.
  assign prod_s   = mcand_r * AW'(mplier_r[K-1:0]);
  assign acc_nx_s = acc_r + prod_s;
  assign last_s   = (iter_r == IW'(L - 1));

  // State register plus registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  // Next-state selection.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    case (state_r)
      IDLE:    accept_s = in_valid;
      BUSY:    step_s   = 1'b1;
      DONE:    step_s   = 1'b0;
      default: step_s   = 1'b0;
    endcase
  end

  // Operand latch, accumulate/shift iterations and result capture on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {AW{1'b0}};
      mplier_r <= {BW{1'b0}};
      acc_r    <= {AW{1'b0}};
      iter_r   <= {IW{1'b0}};
      z_r      <= {(2*N){1'b0}};
`ifdef MUL_SIGNED_EN
      neg_r    <= 1'b0;
`endif
    end else if (accept_s) begin
      mcand_r  <= AW'(a_lat_s);
      mplier_r <= BW'(b_lat_s);
      acc_r    <= {AW{1'b0}};
      iter_r   <= {IW{1'b0}};
`ifdef MUL_SIGNED_EN
      neg_r    <= neg_in_s;
`endif
    end else if (step_s) begin
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_r << K;
      mplier_r <= mplier_r >> K;
      iter_r   <= iter_r + IW'(1);
      if (last_s) begin
        z_r <= z_nx_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign Z         = z_r;

endmodule

// File: tb/tb_mul_usg_seq.sv
// Bench for mul_usg_seq: four instances (K = 1, 4, 3, 11 at N = 11) checked every cycle
// against an arithmetic latency/product model, plus directed literal expectations.
module tb_mul_usg_seq;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_s  [NI];
  logic        out_ready_s [NI];
  logic        sm_s        [NI];
  logic [10:0] a_s         [NI];
  logic [10:0] b_s         [NI];
  logic        in_ready_o  [NI];
  logic        out_valid_o [NI];
  logic        busy_o      [NI];
  logic [21:0] z_o         [NI];

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  bit run_r [NI];

  // model state: 0 idle, 1 computing, 2 holding result
  int          m_st    [NI] = '{default: 0};
  int          m_left  [NI] = '{default: 0};
  logic [21:0] m_prod  [NI] = '{default: 22'h0};
  logic [21:0] m_z     [NI] = '{default: 22'h0};
  int          m_acc   [NI] = '{default: 0};
  int          m_abort [NI] = '{default: 0};
  int          d_out   [NI] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int KV = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 3 : 11;
    mul_usg_seq #(.N(11), .K(KV)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_o[g]),
      .A         (a_s[g]),
      .B         (b_s[g]),
`ifdef MUL_SIGNED_EN
      .sign_mode (sm_s[g]),
`endif
      .out_valid (out_valid_o[g]),
      .out_ready (out_ready_s[g]),
      .Z         (z_o[g]),
      .busy      (busy_o[g])
    );
  end

  function automatic int lat_of(input int g);
    case (g)
      0:       return 11;
      1:       return 3;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [21:0] ref_prod(input logic [10:0] a, input logic [10:0] b, input logic sm);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (sm && a[10]) x = x - 2048;
    if (sm && b[10]) y = y - 2048;
    p = x * y;
    return p[21:0];
  endfunction

  function automatic void chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst=%0d got=%0h want=%0h at %0t", nm, g, act, exp, $time);
    end
  endfunction

  // behavioural model: accept -> product after exactly L edges -> hold until out_ready
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        if (m_st[g] != 0) m_abort[g]++;
        m_st[g] = 0;
        m_left[g] = 0;
        m_z[g] = 22'h0;
      end else begin
        if (out_valid_o[g] && out_ready_s[g]) d_out[g]++;
        if (m_st[g] == 0) begin
          if (in_valid_s[g]) begin
            m_prod[g] = ref_prod(a_s[g], b_s[g], sm_s[g]);
            m_left[g] = lat_of(g);
            m_st[g] = 1;
            m_acc[g]++;
          end
        end else if (m_st[g] == 1) begin
          m_left[g]--;
          if (m_left[g] == 0) begin
            m_st[g] = 2;
            m_z[g] = m_prod[g];
          end
        end else if (out_ready_s[g]) begin
          m_st[g] = 0;
        end
      end
    end
  end

  // per-cycle compare of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        chk("in_ready", g, 64'(in_ready_o[g]), 64'(m_st[g] == 0));
        chk("out_valid", g, 64'(out_valid_o[g]), 64'(m_st[g] == 2));
        chk("busy", g, 64'(busy_o[g]), 64'(m_st[g] != 0));
        chk("z", g, 64'(z_o[g]), 64'(m_z[g]));
      end
    end
  end

  // called at a negedge; returns at the negedge right after the accepting edge
  task automatic send(input int g, input logic [10:0] a, input logic [10:0] b, input logic sm, output bit ok);
    a_s[g] = a;
    b_s[g] = b;
    sm_s[g] = sm;
    in_valid_s[g] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (in_ready_o[g]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid_s[g] = 1'b0;
    chk("send_handshake", g, 64'(ok), 64'd1);
  endtask

  task automatic wait_out(input int g, output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid_o[g]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic toggle(input int g);
    while (run_r[g]) begin
      out_ready_s[g] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    out_ready_s[g] = 1'b1;
  endtask

  task automatic sweep(input int g, input int n);
    bit ok;
    logic sm;
    int sent = 0;
    int acc0 = m_acc[g];
    int out0 = d_out[g];
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef MUL_SIGNED_EN
      sm = 1'($urandom);
`else
      sm = 1'b0;
`endif
      send(g, 11'($urandom), 11'($urandom), sm, ok);
      if (ok) sent++;
    end
    run_r[g] = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready_o[g] && !out_valid_o[g]) break;
    end
    chk("sweep_idle", g, 64'(in_ready_o[g]), 64'd1);
    chk("sweep_accepts", g, 64'(m_acc[g] - acc0), 64'(sent));
    chk("sweep_outputs", g, 64'(d_out[g] - out0), 64'(sent));
  endtask

  initial begin
    bit ok;
    int lat;
    for (int g = 0; g < NI; g++) begin
      in_valid_s[g] = 1'b0;
      out_ready_s[g] = 1'b1;
      sm_s[g] = 1'b0;
      a_s[g] = 11'h0;
      b_s[g] = 11'h0;
      run_r[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_in_ready", g, 64'(in_ready_o[g]), 64'd1);
      chk("rst_out_valid", g, 64'(out_valid_o[g]), 64'd0);
      chk("rst_z", g, 64'(z_o[g]), 64'd0);
      chk("rst_busy", g, 64'(busy_o[g]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // K=1: exact 11-cycle latency and handshake-return timing
    send(0, 11'h7FF, 11'h7FF, 1'b0, ok);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("t1_out_valid", 0, 64'(out_valid_o[0]), 64'(k == 11));
      chk("t1_in_ready", 0, 64'(in_ready_o[0]), 64'(k == 12));
      if (k == 11) chk("t1_z", 0, 64'(z_o[0]), 64'h3FF001);
    end

    // K=4: three-cycle latency, zero operand runs full length
    send(1, 11'h400, 11'h400, 1'b0, ok);
    wait_out(1, lat);
    chk("t2_lat", 1, 64'(lat), 64'd3);
    chk("t2_z", 1, 64'(z_o[1]), 64'h100000);
    send(1, 11'h000, 11'h5A5, 1'b0, ok);
    wait_out(1, lat);
    chk("t2_lat_zero", 1, 64'(lat), 64'd3);
    chk("t2_z_zero", 1, 64'(z_o[1]), 64'h0);
    @(negedge clk);

    // backpressure with an ignored in_valid pulse during the stall
    out_ready_s[1] = 1'b0;
    send(1, 11'd3, 11'd5, 1'b0, ok);
    wait_out(1, lat);
    chk("t3_lat", 1, 64'(lat), 64'd3);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        a_s[1] = 11'd7;
        b_s[1] = 11'd7;
        in_valid_s[1] = 1'b1;
      end else begin
        in_valid_s[1] = 1'b0;
      end
      @(negedge clk);
      chk("t3_hold_valid", 1, 64'(out_valid_o[1]), 64'd1);
      chk("t3_hold_z", 1, 64'(z_o[1]), 64'd15);
      chk("t3_hold_ready", 1, 64'(in_ready_o[1]), 64'd0);
    end
    in_valid_s[1] = 1'b0;
    out_ready_s[1] = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", 1, 64'(out_valid_o[1]), 64'd0);
    chk("t3_release_ready", 1, 64'(in_ready_o[1]), 64'd1);
    chk("t3_release_z", 1, 64'(z_o[1]), 64'd15);
    send(1, 11'd2, 11'd6, 1'b0, ok);
    wait_out(1, lat);
    chk("t3_next_z", 1, 64'(z_o[1]), 64'd12);

    // async reset in the middle of a K=1 operation
    send(0, 11'h123, 11'h0F0, 1'b0, ok);
    repeat (5) @(negedge clk);
    chk("t4_busy_before", 0, 64'(busy_o[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 0, 64'(out_valid_o[0]), 64'd0);
    chk("t4_rst_z", 0, 64'(z_o[0]), 64'd0);
    chk("t4_rst_ready", 0, 64'(in_ready_o[0]), 64'd1);
    chk("t4_rst_busy", 0, 64'(busy_o[0]), 64'd0);
    chk("t4_rst_z_other", 1, 64'(z_o[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 11'd2, 11'd9, 1'b0, ok);
    wait_out(0, lat);
    chk("t4_lat", 0, 64'(lat), 64'd11);
    chk("t4_z", 0, 64'(z_o[0]), 64'd18);

`ifdef MUL_SIGNED_EN
    send(3, 11'h400, 11'h7FF, 1'b1, ok);
    wait_out(3, lat);
    chk("s_lat", 3, 64'(lat), 64'd1);
    chk("s_neg_neg", 3, 64'(z_o[3]), 64'h000400);
    send(3, 11'h400, 11'h001, 1'b1, ok);
    wait_out(3, lat);
    chk("s_neg_pos", 3, 64'(z_o[3]), 64'h3FFC00);
    send(3, 11'h400, 11'h7FF, 1'b0, ok);
    wait_out(3, lat);
    chk("s_unsigned", 3, 64'(z_o[3]), 64'h1FFC00);
`endif
    @(negedge clk);

    // randomised sweep on K = 1, 3, 11 with random out_ready gaps
    run_r[0] = 1'b1;
    run_r[2] = 1'b1;
    run_r[3] = 1'b1;
    fork
      sweep(0, 340);
      sweep(2, 340);
      sweep(3, 340);
      toggle(0);
      toggle(2);
      toggle(3);
    join
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
